// File: rtl/traffic_phase_sched.sv
// Request-driven phase scheduler for a main/side intersection with pedestrian walk
// and main-road emergency preemption. Single driver of every lamp output.
module traffic_phase_sched #(
    parameter int MIN_MAIN  = 6,
    parameter int Y_TIME    = 2,
    parameter int AR_TIME   = 1,
    parameter int WALK_TIME = 4,
    parameter int SIDE_TIME = 5,
    parameter int TW        = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       car_req,
    input  logic       ped_req,
    input  logic       emg_req,
    output logic       MRR,
    output logic       MRY,
    output logic       MRG,
    output logic       SRR,
    output logic       SRY,
    output logic       SRG,
    output logic       walk,
    output logic       car_pending,
    output logic       ped_pending,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        ALL_R1 = 3'd2,
        WALK   = 3'd3,
        SIDE_G = 3'd4,
        SIDE_Y = 3'd5,
        ALL_R2 = 3'd6
    } state_t;

    localparam logic [TW-1:0] MAIN_LAST = TW'(MIN_MAIN - 1);
    localparam logic [TW-1:0] Y_LAST    = TW'(Y_TIME - 1);
    localparam logic [TW-1:0] AR_LAST   = TW'(AR_TIME - 1);
    localparam logic [TW-1:0] WALK_LAST = TW'(WALK_TIME - 1);
    localparam logic [TW-1:0] SIDE_LAST = TW'(SIDE_TIME - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          car_pending_q, car_pending_d;
    logic          ped_pending_q, ped_pending_d;
    logic [TW-1:0] last;
    logic          expire;

    always_comb begin
        case (state_q)
            MAIN_G:         last = MAIN_LAST;
            MAIN_Y, SIDE_Y: last = Y_LAST;
            WALK:           last = WALK_LAST;
            SIDE_G:         last = SIDE_LAST;
            default:        last = AR_LAST;
        endcase
    end

    assign expire = tick && (timer_q == last);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (tick && !expire) timer_d = timer_q + 1'b1;
        case (state_q)
            // Without a serviceable request the timer simply stays saturated.
            MAIN_G: if (expire && (car_pending_q || ped_pending_q) && !emg_req) state_d = MAIN_Y;
            MAIN_Y: if (expire) state_d = ALL_R1;
            ALL_R1: if (expire) begin
                if (emg_req)            state_d = MAIN_G;
                else if (ped_pending_q) state_d = WALK;
                else if (car_pending_q) state_d = SIDE_G;
                else                    state_d = MAIN_G;
            end
            // Emergency cuts do not wait for a tick.
            WALK: begin
                if (emg_req)      state_d = ALL_R2;
                else if (expire)  state_d = car_pending_q ? SIDE_G : ALL_R2;
            end
            SIDE_G: if (emg_req || expire) state_d = SIDE_Y;
            SIDE_Y: if (expire) state_d = ALL_R2;
            ALL_R2: if (expire) state_d = MAIN_G;
            default: state_d = MAIN_G;
        endcase
        if (state_d != state_q) timer_d = '0;

        car_pending_d = car_pending_q | car_req;
        if (state_d == SIDE_G && state_q != SIDE_G) car_pending_d = 1'b0;
        ped_pending_d = ped_pending_q | ped_req;
        if (state_d == WALK && state_q != WALK) ped_pending_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= MAIN_G;
            timer_q       <= '0;
            car_pending_q <= 1'b0;
            ped_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            car_pending_q <= car_pending_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    // Lamps decode the state flop directly; unknown codes fall back to all red.
    always_comb begin
        {MRR, MRY, MRG, SRR, SRY, SRG, walk} = 7'b1001000;
        case (state_q)
            MAIN_G: {MRR, MRY, MRG, SRR, SRY, SRG, walk} = 7'b0011000;
            MAIN_Y: {MRR, MRY, MRG, SRR, SRY, SRG, walk} = 7'b0101000;
            WALK:   {MRR, MRY, MRG, SRR, SRY, SRG, walk} = 7'b1001001;
            SIDE_G: {MRR, MRY, MRG, SRR, SRY, SRG, walk} = 7'b1000010;
            SIDE_Y: {MRR, MRY, MRG, SRR, SRY, SRG, walk} = 7'b1000100;
            default: ;
        endcase
    end

    assign car_pending = car_pending_q;
    assign ped_pending = ped_pending_q;
    assign phase       = state_q;

endmodule
